// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency memory reads and
// hands {instr, pc} to decode through a 2-entry FIFO with valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    input  logic        dec_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  fifo_instr_q [2];
    logic [XLEN-1:0]  fifo_pc_q    [2];

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Occupancy after this cycle's pop decides whether a new word fits.
    always_comb begin
        valid_out = !reset && (count_q != CNT_W'(0));
        pop       = valid_out && dec_ready;
        occ       = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue     = !reset && !redirect_valid && (occ < OCC_W'(2));
        push      = !reset && !redirect_valid && inflight_q;
        imem_req  = issue;
        imem_addr = reset ? RESET_PC : pc_q;
        instr_out = valid_out ? fifo_instr_q[head_q] : '0;
        pc_out    = valid_out ? fifo_pc_q[head_q]    : '0;
    end

    // Next-state: a redirect flushes the FIFO and drops any in-flight word.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            inflight_d = 1'b0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
            count_d    = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + XLEN'(4);
                inflight_pc_d = pc_q;
            end
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[tail_q] <= imem_rdata;
            fifo_pc_q[tail_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table plus an
// in-order delivery check under an irregular backpressure pattern.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic        dec_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .valid_out(valid_out), .dec_ready(dec_ready),
        .instr_out(instr_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1357_2468;
    endfunction

    // Memory with exactly one cycle of read latency; garbage when idle.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;

        //   rst rv  rpc            rdy  req addr           vld pc
        add(1, 0, 32'h0,          1,   0, 32'h100,        0, 32'h0);       // reset
        add(1, 0, 32'h0,          1,   0, 32'h100,        0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h100,        0, 32'h0);       // C0
        add(0, 0, 32'h0,          1,   1, 32'h104,        0, 32'h0);       // C1
        add(0, 0, 32'h0,          1,   1, 32'h108,        1, 32'h100);     // C2 first valid
        add(0, 0, 32'h0,          1,   1, 32'h10C,        1, 32'h104);
        add(0, 0, 32'h0,          0,   0, 32'h110,        1, 32'h108);     // backpressure
        add(0, 0, 32'h0,          0,   0, 32'h110,        1, 32'h108);
        add(0, 0, 32'h0,          1,   1, 32'h110,        1, 32'h108);     // pop resumes issue
        add(0, 0, 32'h0,          1,   1, 32'h114,        1, 32'h10C);
        add(0, 0, 32'h0,          1,   1, 32'h118,        1, 32'h110);
        add(0, 1, 32'h2003,       0,   0, 32'h11C,        1, 32'h114);     // redirect, word in flight
        add(0, 0, 32'h0,          1,   1, 32'h2000,       0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h2004,       0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h2008,       1, 32'h2000);
        add(0, 1, 32'hFFFF_FFF8,  1,   0, 32'h200C,       1, 32'h2004);    // redirect + transfer
        add(0, 0, 32'h0,          1,   1, 32'hFFFF_FFF8,  0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC,  0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h0,          1, 32'hFFFF_FFF8);
        add(0, 0, 32'h0,          1,   1, 32'h4,          1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,          1,   1, 32'h8,          1, 32'h0);
        add(0, 0, 32'h0,          0,   0, 32'hC,          1, 32'h4);
        add(1, 0, 32'h0,          0,   0, 32'h100,        0, 32'h0);       // mid-stream reset
        add(0, 0, 32'h0,          1,   1, 32'h100,        0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h104,        0, 32'h0);
        add(0, 0, 32'h0,          1,   1, 32'h108,        1, 32'h100);
        add(0, 0, 32'h0,          1,   1, 32'h10C,        1, 32'h104);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            dec_ready      = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d.req", i),   32'(imem_req),  32'(vecs[i].req));
            chk($sformatf("v%0d.addr", i),  imem_addr,      vecs[i].addr);
            chk($sformatf("v%0d.valid", i), 32'(valid_out), 32'(vecs[i].vld));
            chk($sformatf("v%0d.pc", i),    pc_out,         vecs[i].pc);
            chk($sformatf("v%0d.instr", i), instr_out,
                vecs[i].vld ? mem_word(vecs[i].pc) : 32'h0);
        end

        // In-order, no-gap, no-duplicate delivery under irregular backpressure.
        begin
            logic [31:0] pattern;
            logic [31:0] exp_pc;
            logic [31:0] prev_pc;
            logic        hold;
            int          delivered;
            pattern   = 32'b1011_0010_1110_0001_1101_0110_0011_1001;
            exp_pc    = RST_PC;
            prev_pc   = '0;
            hold      = 1'b0;
            delivered = 0;
            @(negedge clk);
            reset = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 96; c++) begin
                if (c != 0) @(negedge clk);
                dec_ready = pattern[c % 32];
                #1;
                if (hold) begin
                    chk("hold.valid", 32'(valid_out), 32'd1);
                    chk("hold.pc", pc_out, prev_pc);
                end
                if (valid_out) begin
                    chk("seq.pc", pc_out, exp_pc);
                    chk("seq.instr", instr_out, mem_word(exp_pc));
                    if (dec_ready) begin
                        exp_pc = exp_pc + 32'd4;
                        delivered++;
                    end
                end
                hold    = valid_out && !dec_ready;
                prev_pc = pc_out;
            end
            // 96 cycles with ~half ready must deliver well over 30 words.
            chk("seq.progress", 32'(delivered > 30), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
